// File: rtl/pes_elc_sched_if.sv
// Signal bundle between the pes_elc_sched scheduler and the pes_elc controller side.
// The slave modport is the scheduler's view; master is the controller/call-button side.
interface pes_elc_sched_if;
  logic [7:0] call_req;
  logic [7:0] cur_floor;
  logic       complete;
  logic       hold;
  logic [7:0] target_floor;
  logic       target_valid;
  logic       sched_dir;
  logic       door_open;
  logic [7:0] pending;
  logic       floor_err;

  modport master (
    output call_req, cur_floor, complete, hold,
    input  target_floor, target_valid, sched_dir, door_open, pending, floor_err
  );

  modport slave (
    input  call_req, cur_floor, complete, hold,
    output target_floor, target_valid, sched_dir, door_open, pending, floor_err
  );
endinterface

// File: rtl/pes_elc_sched.sv
// SCAN request scheduler for the pes_elc controller: latches floor calls, picks the next
// target, retargets to intermediate calls while moving and times the door dwell.
module pes_elc_sched #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  pes_elc_sched_if.slave bus
);

  localparam logic [7:0] DwellLoad = 8'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSelect, StMove, StDwell} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] target_q, target_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic [7:0] cur, clr, up_req, dn_req, between;

  function automatic logic [7:0] lowest(input logic [7:0] x);
    return x & (~x + 8'd1);
  endfunction

  function automatic logic [7:0] highest(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) r = 8'd1 << i;
    end
    return r;
  endfunction

  // Masks of floors strictly below / strictly above a one-hot floor.
  function automatic logic [7:0] below_mask(input logic [7:0] f);
    return f - 8'd1;
  endfunction

  function automatic logic [7:0] above_mask(input logic [7:0] f);
    return ~((f - 8'd1) | f);
  endfunction

  assign cur       = bus.cur_floor;
  assign clr       = (state_q == StDwell) ? target_q : 8'h00;
  assign pending_d = (pending_q | bus.call_req) & ~clr;
  assign up_req    = pending_q & above_mask(cur);
  assign dn_req    = pending_q & below_mask(cur);
  assign between   = dir_q ? (up_req & below_mask(target_q)) : (dn_req & above_mask(target_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 8'h00;
      target_q  <= 8'h01;
      cnt_q     <= 8'h00;
      dir_q     <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        target_d = cur;
        valid_d  = 1'b0;
        if (pending_q != 8'h00) state_d = StSelect;
      end
      StSelect: begin
        if (!$onehot(cur)) begin
          err_d = 1'b1;
        end else begin
          err_d   = 1'b0;
          valid_d = 1'b1;
          if ((pending_q & cur) != 8'h00) begin
            target_d = cur;
            cnt_d    = DwellLoad;
            state_d  = StDwell;
          end else begin
            state_d = StMove;
            if (dir_q) begin
              if (up_req != 8'h00) begin
                target_d = lowest(up_req);
              end else begin
                dir_d    = 1'b0;
                target_d = highest(dn_req);
              end
            end else begin
              if (dn_req != 8'h00) begin
                target_d = highest(dn_req);
              end else begin
                dir_d    = 1'b1;
                target_d = lowest(up_req);
              end
            end
          end
        end
      end
      StMove: begin
        // Arrival wins over retargeting; nothing can lie strictly between once there.
        if (bus.complete && (cur == target_q)) begin
          cnt_d   = DwellLoad;
          state_d = StDwell;
        end else if (between != 8'h00) begin
          target_d = dir_q ? lowest(between) : highest(between);
        end
      end
      StDwell: begin
        if (!bus.hold) begin
          if (cnt_q == 8'h00) begin
            if (pending_d != 8'h00) begin
              state_d = StSelect;
            end else begin
              state_d = StIdle;
              valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.target_floor = target_q;
    bus.target_valid = valid_q;
    bus.sched_dir    = dir_q;
    bus.door_open    = (state_q == StDwell);
    bus.pending      = pending_q;
    bus.floor_err    = err_q;
  end

endmodule

// File: tb/tb_pes_elc_sched.sv
// Self-checking bench for pes_elc_sched: a one-floor-per-cycle car model plus a scoreboard
// of expected service order, direction and dwell length per stop.
module tb_pes_elc_sched;

  typedef struct {
    logic [7:0] floor;
    logic       dir;
    int         len;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   hold_len;
  logic [7:0] absorb_call;
  exp_t exp_q[$];
  exp_t cur_exp;

  pes_elc_sched_if bif ();

  pes_elc_sched #(
    .DWELL_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_call(input logic [7:0] v);
    bif.call_req = v;
    tick();
    bif.call_req = 8'h00;
  endtask

  // Drives controller-side inputs for the current cycle from the last sampled outputs.
  task automatic car_step(input int door_cnt);
    bif.hold = (hold_len > 0) && bif.door_open && (door_cnt >= 2) && (door_cnt < 2 + hold_len);
    bif.call_req = (absorb_call != 8'h00 && bif.door_open && door_cnt == 2) ? absorb_call : 8'h00;
    if (bif.target_valid && !bif.door_open && bif.cur_floor != bif.target_floor) begin
      bif.cur_floor = (bif.target_floor > bif.cur_floor) ? (bif.cur_floor << 1)
                                                          : (bif.cur_floor >> 1);
    end
    bif.complete = bif.target_valid && !bif.door_open && (bif.cur_floor == bif.target_floor);
  endtask

  task automatic run_trips(input int budget);
    int  door_cnt;
    bit  done;
    door_cnt = 0;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      car_step(door_cnt);
      tick();
      if (bif.door_open) begin
        door_cnt++;
        if (door_cnt == 1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dwell: got floor %h, expected no dwell", bif.target_floor);
            cur_exp.floor = bif.target_floor;
            cur_exp.dir   = bif.sched_dir;
            cur_exp.len   = 4;
          end else begin
            cur_exp = exp_q.pop_front();
            if (bif.target_floor !== cur_exp.floor) begin
              errors++;
              $display("FAIL stop_floor: got %h expected %h", bif.target_floor, cur_exp.floor);
            end
            checks++;
            if (bif.sched_dir !== cur_exp.dir) begin
              errors++;
              $display("FAIL stop_dir at %h: got %b expected %b", cur_exp.floor, bif.sched_dir,
                       cur_exp.dir);
            end
          end
        end
      end else if (door_cnt != 0) begin
        checks++;
        if (door_cnt != cur_exp.len) begin
          errors++;
          $display("FAIL dwell_len at %h: got %0d expected %0d", cur_exp.floor, door_cnt,
                   cur_exp.len);
        end
        door_cnt = 0;
        if (exp_q.size() == 0) done = 1;
      end
    end
    bif.hold     = 1'b0;
    bif.call_req = 8'h00;
    bif.complete = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL trip_timeout: got %0d stops left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (bif.target_floor !== 8'h01) begin
      errors++; $display("FAIL %s target_floor: got %h expected 01", tag, bif.target_floor);
    end
    checks++;
    if (bif.target_valid !== 1'b0) begin
      errors++; $display("FAIL %s target_valid: got %b expected 0", tag, bif.target_valid);
    end
    checks++;
    if (bif.sched_dir !== 1'b1) begin
      errors++; $display("FAIL %s sched_dir: got %b expected 1", tag, bif.sched_dir);
    end
    checks++;
    if (bif.door_open !== 1'b0) begin
      errors++; $display("FAIL %s door_open: got %b expected 0", tag, bif.door_open);
    end
    checks++;
    if (bif.pending !== 8'h00) begin
      errors++; $display("FAIL %s pending: got %h expected 00", tag, bif.pending);
    end
    checks++;
    if (bif.floor_err !== 1'b0) begin
      errors++; $display("FAIL %s floor_err: got %b expected 0", tag, bif.floor_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bif.call_req = 8'h00; bif.cur_floor = 8'h01; bif.complete = 1'b0; bif.hold = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();
  endtask

  task automatic test_simple_trip();
    pulse_call(8'h10);
    checks++;
    if (bif.pending !== 8'h10) begin
      errors++; $display("FAIL simple_pending: got %h expected 10", bif.pending);
    end
    tick();
    checks++;
    if (bif.target_valid !== 1'b0) begin
      errors++; $display("FAIL simple_select_valid: got %b expected 0", bif.target_valid);
    end
    tick();
    checks++;
    if (bif.target_floor !== 8'h10 || bif.target_valid !== 1'b1) begin
      errors++;
      $display("FAIL simple_target: got %h/%b expected 10/1", bif.target_floor, bif.target_valid);
    end
    exp_q.push_back('{floor: 8'h10, dir: 1'b1, len: 4});
    run_trips(100);
    checks++;
    if (bif.pending !== 8'h00 || bif.target_valid !== 1'b0) begin
      errors++;
      $display("FAIL simple_after: got pending %h valid %b expected 00/0", bif.pending,
               bif.target_valid);
    end
  endtask

  task automatic test_scan_order();
    bif.cur_floor = 8'h04;
    tick();
    pulse_call(8'hA1);
    exp_q.push_back('{floor: 8'h20, dir: 1'b1, len: 4});
    exp_q.push_back('{floor: 8'h80, dir: 1'b1, len: 4});
    exp_q.push_back('{floor: 8'h01, dir: 1'b0, len: 4});
    run_trips(300);
  endtask

  task automatic test_retarget();
    pulse_call(8'h80);
    tick();
    tick();
    checks++;
    if (bif.target_floor !== 8'h80 || bif.sched_dir !== 1'b1) begin
      errors++;
      $display("FAIL retarget_start: got %h dir %b expected 80 dir 1", bif.target_floor,
               bif.sched_dir);
    end
    bif.cur_floor = 8'h02;
    tick();
    bif.cur_floor = 8'h04;
    tick();
    pulse_call(8'h10);
    checks++;
    if (bif.pending !== 8'h90) begin
      errors++; $display("FAIL retarget_pending: got %h expected 90", bif.pending);
    end
    tick();
    checks++;
    if (bif.target_floor !== 8'h10) begin
      errors++; $display("FAIL retarget_target: got %h expected 10", bif.target_floor);
    end
    checks++;
    if (bif.pending[7] !== 1'b1) begin
      errors++; $display("FAIL retarget_keep80: got %b expected 1", bif.pending[7]);
    end
    exp_q.push_back('{floor: 8'h10, dir: 1'b1, len: 4});
    exp_q.push_back('{floor: 8'h80, dir: 1'b1, len: 4});
    run_trips(200);
  endtask

  task automatic test_hold_dwell();
    hold_len = 3;
    pulse_call(8'h40);
    exp_q.push_back('{floor: 8'h40, dir: 1'b0, len: 7});
    run_trips(100);
    hold_len = 0;
  endtask

  task automatic test_same_floor();
    int door_cycles;
    int extra;
    pulse_call(8'h40);
    tick();
    tick();
    checks++;
    if (bif.door_open !== 1'b1 || bif.target_floor !== 8'h40) begin
      errors++;
      $display("FAIL same_floor_dwell: got door %b target %h expected 1/40", bif.door_open,
               bif.target_floor);
    end
    door_cycles = 1;
    for (int i = 0; i < 20 && bif.door_open; i++) begin
      bif.call_req = (door_cycles == 2) ? 8'h40 : 8'h00;
      tick();
      if (bif.door_open) door_cycles++;
    end
    bif.call_req = 8'h00;
    checks++;
    if (door_cycles != 4) begin
      errors++; $display("FAIL same_floor_len: got %0d expected 4", door_cycles);
    end
    checks++;
    if (bif.pending !== 8'h00) begin
      errors++; $display("FAIL same_floor_absorb: got %h expected 00", bif.pending);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bif.door_open) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL same_floor_redwell: got %0d cycles expected 0", extra);
    end
  endtask

  task automatic test_floor_err();
    bif.cur_floor = 8'h03;
    pulse_call(8'h01);
    tick();
    tick();
    checks++;
    if (bif.floor_err !== 1'b1) begin
      errors++; $display("FAIL floor_err_set: got %b expected 1", bif.floor_err);
    end
    tick();
    tick();
    checks++;
    if (bif.floor_err !== 1'b1 || bif.target_valid !== 1'b0 || bif.door_open !== 1'b0) begin
      errors++;
      $display("FAIL floor_err_stay: got err %b valid %b door %b expected 1/0/0",
               bif.floor_err, bif.target_valid, bif.door_open);
    end
    bif.cur_floor = 8'h02;
    tick();
    checks++;
    if (bif.floor_err !== 1'b0 || bif.target_floor !== 8'h01 || bif.target_valid !== 1'b1) begin
      errors++;
      $display("FAIL floor_err_clear: got err %b target %h valid %b expected 0/01/1",
               bif.floor_err, bif.target_floor, bif.target_valid);
    end
    exp_q.push_back('{floor: 8'h01, dir: 1'b0, len: 4});
    run_trips(50);
  endtask

  task automatic test_reset_mid_move();
    pulse_call(8'h80);
    tick();
    tick();
    bif.cur_floor = 8'h02;
    tick();
    bif.cur_floor = 8'h04;
    tick();
    checks++;
    if (bif.target_valid !== 1'b1) begin
      errors++; $display("FAIL mid_move_valid: got %b expected 1", bif.target_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick();
    #3;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bif.pending !== 8'h00 || bif.target_valid !== 1'b0 || bif.door_open !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got pending %h valid %b door %b expected 00/0/0",
               bif.pending, bif.target_valid, bif.door_open);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hold_len = 0;
    absorb_call = 8'h00;
    test_reset();
    test_simple_trip();
    test_scan_order();
    test_retarget();
    test_hold_dwell();
    test_same_floor();
    test_floor_err();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
